cordic_exp_iter_ctrl: RTL

- Iteration sequencer for the floating-point hyperbolic CORDIC exponential unit.
- Sits directly upstream of the Z-angle constant ROM: drives its address and read-enable, times the one-cycle ROM latency, and paces the X/Y/Z datapath one iteration at a time through a start/done handshake.
- Owns the iteration counter and the per-iteration shift amount; it performs no arithmetic on operand data.

---
 rtl/cordic_exp_pkg.sv | 19 +
 rtl/cordic_exp_iter_ctrl_if.sv | 30 +++
 rtl/cordic_iter_counter.sv | 43 ++++
 rtl/cordic_exp_iter_ctrl.sv | 112 +++++++++++
 4 files changed

// File: rtl/cordic_exp_pkg.sv
// Shared definitions for the hyperbolic CORDIC exponential unit: default
// sizes and the iteration sequencer state encoding.
package cordic_exp_pkg;

  // ROM address / iteration counter width.
  localparam int D_DEF      = 5;
  // CORDIC iterations per operation.
  localparam int N_ITER_DEF = 26;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_FETCH   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_WAIT    = 3'd4,
    ST_DONE    = 3'd5
  } iter_state_e;

endpackage

// File: rtl/cordic_exp_iter_ctrl_if.sv
// Handshake and ROM-side bundle of the iteration sequencer. The master is
// the sequencer; the slave is the host/datapath side that starts operations,
// reports iteration completion and acknowledges results.
interface cordic_exp_iter_ctrl_if
  import cordic_exp_pkg::*;
#(
  parameter int D = D_DEF
);

  logic         BEG_FSM;
  logic         ACK_FSM;
  logic         DP_DONE;
  logic         EN_ROM1;
  logic [D-1:0] ADRS;
  logic [D-1:0] SHIFT;
  logic         LOAD_INIT;
  logic         ITER_GO;
  logic         RDY;

  modport master (
    input  BEG_FSM, ACK_FSM, DP_DONE,
    output EN_ROM1, ADRS, SHIFT, LOAD_INIT, ITER_GO, RDY
  );

  modport slave (
    output BEG_FSM, ACK_FSM, DP_DONE,
    input  EN_ROM1, ADRS, SHIFT, LOAD_INIT, ITER_GO, RDY
  );

endinterface

// File: rtl/cordic_iter_counter.sv
// D-bit iteration counter with synchronous clear and increment enable.
// Exposes the current index k and k+1 (modulo 2^D).
module cordic_iter_counter #(
  parameter int D = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [D-1:0] k,
  output logic [D-1:0] k_p1
);

  logic [D-1:0] k_d;
  logic [D-1:0] k_q;

  // Next count: clear has priority over increment.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    k_d = k_q;
    if (clr) begin
      k_d = '0;
    end else if (inc) begin
      k_d = k_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (!rst_n) begin
      k_q <= '0;
    end else begin
      k_q <= k_d;
    end
  end

  assign k    = k_q;
  assign k_p1 = k_q + 1'b1;

endmodule

// File: rtl/cordic_exp_iter_ctrl.sv
// Iteration sequencer for the hyperbolic CORDIC exponential unit. Drives the
// Z-angle ROM address/enable, covers its one-cycle read latency and paces the
// X/Y/Z datapath one iteration at a time. Every output is a flop.
module cordic_exp_iter_ctrl
  import cordic_exp_pkg::*;
#(
  parameter int D      = D_DEF,
  parameter int N_ITER = N_ITER_DEF
) (
  input  logic                   CLK,
  input  logic                   RST,
  cordic_exp_iter_ctrl_if.master bus
);

  // Index of the final iteration; with N_ITER = 2^D this is all-ones, so the
  // counter reaches its top value and stops there without wrapping.
  localparam logic [D-1:0] K_LAST = D'(N_ITER - 1);

  iter_state_e  state_d, state_q;
  logic         k_clr, k_inc;
  logic [D-1:0] k, k_p1;
  logic [D-1:0] shift_d, shift_q;
  logic         en_rom1_d, en_rom1_q;
  logic         load_init_d, load_init_q;
  logic         iter_go_d, iter_go_q;
  logic         rdy_d, rdy_q;

  cordic_iter_counter #(.D(D)) u_counter (
    .clk   (CLK),
    .rst_n (RST),
    .clr   (k_clr),
    .inc   (k_inc),
    .k     (k),
    .k_p1  (k_p1)
  );

  // Sequencer transitions; each input is looked at only in its own state.
  always_comb begin
    state_d = state_q;
    k_clr   = 1'b0;
    k_inc   = 1'b0;
    unique case (state_q)
      ST_IDLE:    if (bus.BEG_FSM) state_d = ST_LOAD;
      ST_LOAD:    state_d = ST_FETCH;
      ST_FETCH:   state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (bus.DP_DONE) begin
          if (k == K_LAST) begin
            state_d = ST_DONE;
          end else begin
            k_inc   = 1'b1;
            state_d = ST_FETCH;
          end
        end
      end
      ST_DONE: begin
        if (bus.ACK_FSM) begin
          k_clr   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        k_clr   = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output values for the state being entered, so they register alongside it.
  always_comb begin
    en_rom1_d   = (state_d == ST_FETCH);
    load_init_d = (state_d == ST_LOAD);
    iter_go_d   = (state_d == ST_CAPTURE);
    rdy_d       = (state_d == ST_DONE);
    shift_d     = shift_q;
    if (state_d == ST_IDLE) begin
      shift_d = '0;
    end else if (state_d == ST_FETCH) begin
      // k advances on this same edge when coming from WAIT, so the shift
      // for the new index is one beyond the current k+1.
      shift_d = k_inc ? (k_p1 + 1'b1) : k_p1;
    end
  end

  // State and registered outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      en_rom1_q   <= 1'b0;
      load_init_q <= 1'b0;
      iter_go_q   <= 1'b0;
      rdy_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      en_rom1_q   <= en_rom1_d;
      load_init_q <= load_init_d;
      iter_go_q   <= iter_go_d;
      rdy_q       <= rdy_d;
    end
  end

  assign bus.EN_ROM1   = en_rom1_q;
  assign bus.ADRS      = k;
  assign bus.SHIFT     = shift_q;
  assign bus.LOAD_INIT = load_init_q;
  assign bus.ITER_GO   = iter_go_q;
  assign bus.RDY       = rdy_q;

endmodule
